// File: rtl/int_alu_rsv_station_if.sv
// Issue, CDB snoop and dispatch signals of the integer ALU reservation station.
// The slave modport is the station; the master modport is the issue/CDB/ALU side.
interface int_alu_rsv_station_if;
    logic        issue_vld;
    logic [3:0]  issue_opcode;
    logic [4:0]  issue_tag;
    logic        issue_src1_rdy;
    logic [31:0] issue_src1_val;
    logic [4:0]  issue_src1_tag;
    logic        issue_src2_rdy;
    logic [31:0] issue_src2_val;
    logic [4:0]  issue_src2_tag;
    logic [4:0]  issue_shfamt;
    logic        rs_full;
    logic        cdb_vld;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_dat;
    logic        disp_rdy;
    logic        disp_vld;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  shf_amt;
    logic [4:0]  tag_out;
    logic [3:0]  alu_opcode;

    modport slave (
        input  issue_vld, issue_opcode, issue_tag,
        input  issue_src1_rdy, issue_src1_val, issue_src1_tag,
        input  issue_src2_rdy, issue_src2_val, issue_src2_tag, issue_shfamt,
        input  cdb_vld, cdb_tag, cdb_dat, disp_rdy,
        output rs_full, disp_vld, operand1, operand2, shf_amt, tag_out, alu_opcode
    );

    modport master (
        output issue_vld, issue_opcode, issue_tag,
        output issue_src1_rdy, issue_src1_val, issue_src1_tag,
        output issue_src2_rdy, issue_src2_val, issue_src2_tag, issue_shfamt,
        output cdb_vld, cdb_tag, cdb_dat, disp_rdy,
        input  rs_full, disp_vld, operand1, operand2, shf_amt, tag_out, alu_opcode
    );
endinterface

// File: rtl/int_alu_rsv_station.sv
// Integer ALU reservation station: DEPTH entries snooping the CDB, lowest-index ready entry dispatched.
// Issue-to-dispatch latency 2 cycles; dispatch register holds while disp_vld && !disp_rdy, issues dropped when full.
module int_alu_rsv_station #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    int_alu_rsv_station_if.slave  rs
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic        vld;
        logic [3:0]  opcode;
        logic [4:0]  tag;
        logic [4:0]  shamt;
        logic        s1_rdy;
        logic [31:0] s1_val;
        logic [4:0]  s1_tag;
        logic        s2_rdy;
        logic [31:0] s2_val;
        logic [4:0]  s2_tag;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    entry_t new_ent;
    entry_t sel_ent;

    logic [DEPTH-1:0] vld_vec;
    logic [DEPTH-1:0] elig_vec;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    sel_idx;
    logic             any_elig;
    logic             alloc_en;
    logic             load_en;
    logic             do_load;

    logic        disp_vld_q;
    logic [31:0] operand1_q;
    logic [31:0] operand2_q;
    logic [4:0]  shf_amt_q;
    logic [4:0]  tag_out_q;
    logic [3:0]  alu_opcode_q;

    // Descending scan leaves the lowest matching index in free_idx / sel_idx.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        sel_ent  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_vec[i]  = ent_q[i].vld;
            elig_vec[i] = ent_q[i].vld && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_vec[i]) begin
                free_idx = IW'(i);
            end
            if (elig_vec[i]) begin
                sel_idx = IW'(i);
                sel_ent = ent_q[i];
            end
        end
        any_elig = |elig_vec;
    end

    assign rs.rs_full = &vld_vec;
    assign alloc_en   = rs.issue_vld && !rs.rs_full && !flush_i;
    assign load_en    = !disp_vld_q || rs.disp_rdy;
    assign do_load    = load_en && any_elig && !flush_i;

    // A source broadcast in the issue cycle is captured directly into the new entry.
    always_comb begin
        new_ent        = '0;
        new_ent.vld    = 1'b1;
        new_ent.opcode = rs.issue_opcode;
        new_ent.tag    = rs.issue_tag;
        new_ent.shamt  = rs.issue_shfamt;
        new_ent.s1_tag = rs.issue_src1_tag;
        new_ent.s2_tag = rs.issue_src2_tag;
        new_ent.s1_rdy = rs.issue_src1_rdy || (rs.cdb_vld && rs.cdb_tag == rs.issue_src1_tag);
        new_ent.s2_rdy = rs.issue_src2_rdy || (rs.cdb_vld && rs.cdb_tag == rs.issue_src2_tag);
        new_ent.s1_val = rs.issue_src1_rdy ? rs.issue_src1_val : rs.cdb_dat;
        new_ent.s2_val = rs.issue_src2_rdy ? rs.issue_src2_val : rs.cdb_dat;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].vld && !ent_q[i].s1_rdy && rs.cdb_vld && rs.cdb_tag == ent_q[i].s1_tag) begin
                ent_d[i].s1_rdy = 1'b1;
                ent_d[i].s1_val = rs.cdb_dat;
            end
            if (ent_q[i].vld && !ent_q[i].s2_rdy && rs.cdb_vld && rs.cdb_tag == ent_q[i].s2_tag) begin
                ent_d[i].s2_rdy = 1'b1;
                ent_d[i].s2_val = rs.cdb_dat;
            end
            if (do_load && sel_idx == IW'(i)) begin
                ent_d[i].vld = 1'b0;
            end
            // The freed slot was valid at cycle start, so it never collides with free_idx.
            if (alloc_en && free_idx == IW'(i)) begin
                ent_d[i] = new_ent;
            end
            if (flush_i) begin
                ent_d[i].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            disp_vld_q   <= 1'b0;
            operand1_q   <= '0;
            operand2_q   <= '0;
            shf_amt_q    <= '0;
            tag_out_q    <= '0;
            alu_opcode_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            if (flush_i) begin
                disp_vld_q <= 1'b0;
            end else if (load_en) begin
                disp_vld_q <= any_elig;
                if (any_elig) begin
                    operand1_q   <= sel_ent.s1_val;
                    operand2_q   <= sel_ent.s2_val;
                    shf_amt_q    <= sel_ent.shamt;
                    tag_out_q    <= sel_ent.tag;
                    alu_opcode_q <= sel_ent.opcode;
                end
            end
        end
    end

    assign rs.disp_vld   = disp_vld_q;
    assign rs.operand1   = operand1_q;
    assign rs.operand2   = operand2_q;
    assign rs.shf_amt    = shf_amt_q;
    assign rs.tag_out    = tag_out_q;
    assign rs.alu_opcode = alu_opcode_q;
endmodule

// File: tb/tb_int_alu_rsv_station.sv
// Bench for int_alu_rsv_station: directed scenarios then random traffic, all cycles compared to a slot-list model.
module tb_int_alu_rsv_station;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    int_alu_rsv_station_if bus ();
    int_alu_rsv_station #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .flush_i(flush), .rs(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        vld;
        bit [3:0]  op;
        bit [4:0]  tag;
        bit [4:0]  sh;
        bit        r1;
        bit [31:0] v1;
        bit [4:0]  t1;
        bit        r2;
        bit [31:0] v2;
        bit [4:0]  t2;
    } ment_t;

    ment_t     m [4];
    bit        md_vld;
    bit [31:0] md_o1, md_o2;
    bit [4:0]  md_sh, md_tag;
    bit [3:0]  md_op;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic bit model_full();
        bit f = 1'b1;
        foreach (m[i]) f &= m[i].vld;
        return f;
    endfunction

    task automatic model_clear();
        foreach (m[i]) m[i] = '{default: '0};
        md_vld = 0; md_o1 = 0; md_o2 = 0; md_sh = 0; md_tag = 0; md_op = 0;
    endtask

    // Applies one clock edge worth of behaviour, using the state as it was at cycle start.
    task automatic model_step();
        ment_t pre [4];
        int slot = -1;
        int pick = -1;
        pre = m;
        if (flush) begin
            foreach (m[i]) m[i].vld = 0;
            md_vld = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!pre[i].vld && slot < 0) slot = i;
                if (pre[i].vld && pre[i].r1 && pre[i].r2 && pick < 0) pick = i;
            end
            if (!md_vld || bus.disp_rdy) begin
                if (pick >= 0) begin
                    md_vld = 1; md_o1 = pre[pick].v1; md_o2 = pre[pick].v2;
                    md_sh = pre[pick].sh; md_tag = pre[pick].tag; md_op = pre[pick].op;
                    m[pick].vld = 0;
                end else begin
                    md_vld = 0;
                end
            end
            if (bus.cdb_vld) begin
                for (int i = 0; i < 4; i++) begin
                    if (pre[i].vld && !pre[i].r1 && pre[i].t1 == bus.cdb_tag) begin m[i].r1 = 1; m[i].v1 = bus.cdb_dat; end
                    if (pre[i].vld && !pre[i].r2 && pre[i].t2 == bus.cdb_tag) begin m[i].r2 = 1; m[i].v2 = bus.cdb_dat; end
                end
            end
            if (bus.issue_vld && slot >= 0) begin
                m[slot].vld = 1; m[slot].op = bus.issue_opcode; m[slot].tag = bus.issue_tag;
                m[slot].sh = bus.issue_shfamt; m[slot].t1 = bus.issue_src1_tag; m[slot].t2 = bus.issue_src2_tag;
                m[slot].r1 = bus.issue_src1_rdy || (bus.cdb_vld && bus.cdb_tag == bus.issue_src1_tag);
                m[slot].r2 = bus.issue_src2_rdy || (bus.cdb_vld && bus.cdb_tag == bus.issue_src2_tag);
                m[slot].v1 = bus.issue_src1_rdy ? bus.issue_src1_val : bus.cdb_dat;
                m[slot].v2 = bus.issue_src2_rdy ? bus.issue_src2_val : bus.cdb_dat;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("disp_vld", bus.disp_vld, md_vld);
        chk("rs_full", bus.rs_full, model_full());
        if (md_vld) begin
            chk("operand1", bus.operand1, md_o1);
            chk("operand2", bus.operand2, md_o2);
            chk("shf_amt", bus.shf_amt, md_sh);
            chk("tag_out", bus.tag_out, md_tag);
            chk("alu_opcode", bus.alu_opcode, md_op);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_issue(input bit [3:0] op, input bit [4:0] tag,
                             input bit r1, input bit [31:0] v1, input bit [4:0] t1,
                             input bit r2, input bit [31:0] v2, input bit [4:0] t2, input bit [4:0] sh);
        bus.issue_vld = 1; bus.issue_opcode = op; bus.issue_tag = tag; bus.issue_shfamt = sh;
        bus.issue_src1_rdy = r1; bus.issue_src1_val = v1; bus.issue_src1_tag = t1;
        bus.issue_src2_rdy = r2; bus.issue_src2_val = v2; bus.issue_src2_tag = t2;
    endtask

    task automatic issue_tick(input bit [3:0] op, input bit [4:0] tag,
                              input bit r1, input bit [31:0] v1, input bit [4:0] t1,
                              input bit r2, input bit [31:0] v2, input bit [4:0] t2);
        set_issue(op, tag, r1, v1, t1, r2, v2, t2, 5'd0);
        tick();
        bus.issue_vld = 0;
    endtask

    task automatic cdb_tick(input bit [4:0] tag, input bit [31:0] dat);
        bus.cdb_vld = 1; bus.cdb_tag = tag; bus.cdb_dat = dat;
        tick();
        bus.cdb_vld = 0;
    endtask

    task automatic reset_and_check();
        rst = 1;
        #1;
        chk("rst_disp_vld", bus.disp_vld, 0);
        chk("rst_operand1", bus.operand1, 0);
        chk("rst_operand2", bus.operand2, 0);
        chk("rst_shf_amt", bus.shf_amt, 0);
        chk("rst_tag_out", bus.tag_out, 0);
        chk("rst_alu_opcode", bus.alu_opcode, 0);
        chk("rst_rs_full", bus.rs_full, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        bus.issue_vld = 0; bus.issue_opcode = 0; bus.issue_tag = 0; bus.issue_shfamt = 0;
        bus.issue_src1_rdy = 0; bus.issue_src1_val = 0; bus.issue_src1_tag = 0;
        bus.issue_src2_rdy = 0; bus.issue_src2_val = 0; bus.issue_src2_tag = 0;
        bus.cdb_vld = 0; bus.cdb_tag = 0; bus.cdb_dat = 0; bus.disp_rdy = 1;
        model_clear();
        reset_and_check();

        // ADD, both sources ready: dispatch visible two cycles after issue.
        issue_tick(4'h0, 5'd5, 1, 32'd3, 5'd0, 1, 32'd4, 5'd0);
        chk("add_early", bus.disp_vld, 0);
        tick();
        chk("add_vld", bus.disp_vld, 1);
        chk("add_op1", bus.operand1, 32'd3);
        chk("add_op2", bus.operand2, 32'd4);
        chk("add_tag", bus.tag_out, 32'd5);
        chk("add_opc", bus.alu_opcode, 32'd0);
        tick();

        // SUB waiting on tag 9, woken three cycles later.
        issue_tick(4'h1, 5'd6, 0, 32'd0, 5'd9, 1, 32'd2, 5'd0);
        idle(2);
        cdb_tick(5'd9, 32'h10);
        chk("sub_wait", bus.disp_vld, 0);
        tick();
        chk("sub_vld", bus.disp_vld, 1);
        chk("sub_op1", bus.operand1, 32'h10);
        tick();

        // Issue-cycle bypass from the CDB.
        bus.cdb_vld = 1; bus.cdb_tag = 5'd7; bus.cdb_dat = 32'hAA;
        issue_tick(4'hA, 5'd8, 0, 32'd0, 5'd7, 1, 32'd1, 5'd0);
        bus.cdb_vld = 0;
        tick();
        chk("byp_vld", bus.disp_vld, 1);
        chk("byp_op1", bus.operand1, 32'hAA);
        chk("byp_opc", bus.alu_opcode, 32'hA);
        idle(2);

        // Fill, drop a fifth issue, wake slot 2, refill it.
        for (int k = 0; k < 4; k++)
            issue_tick(4'h2, 5'(20 + k), 0, 32'd0, 5'(10 + k), 1, 32'h5, 5'd0);
        chk("fill_full", bus.rs_full, 1);
        issue_tick(4'h3, 5'd30, 1, 32'h77, 5'd0, 1, 32'h78, 5'd0);
        idle(2);
        chk("drop_vld", bus.disp_vld, 0);
        cdb_tick(5'd12, 32'hC12);
        tick();
        chk("wake2_vld", bus.disp_vld, 1);
        chk("wake2_tag", bus.tag_out, 32'd22);
        chk("wake2_full", bus.rs_full, 0);
        issue_tick(4'h4, 5'd25, 0, 32'd0, 5'd13, 1, 32'h9, 5'd0);
        cdb_tick(5'd13, 32'hD13);
        tick();
        chk("refill_first", bus.tag_out, 32'd25);
        tick();
        chk("refill_second", bus.tag_out, 32'd23);
        cdb_tick(5'd10, 32'hA);
        cdb_tick(5'd11, 32'hB);
        idle(4);

        // Backpressure hold, then release in index order.
        bus.disp_rdy = 0;
        issue_tick(4'h5, 5'd1, 1, 32'h11, 5'd0, 1, 32'h12, 5'd0);
        issue_tick(4'h6, 5'd2, 1, 32'h21, 5'd0, 1, 32'h22, 5'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_tag", bus.tag_out, 32'd1);
            chk("hold_op1", bus.operand1, 32'h11);
        end
        bus.disp_rdy = 1;
        tick();
        chk("rel_tag", bus.tag_out, 32'd2);
        tick();
        chk("rel_empty", bus.disp_vld, 0);

        // Flush together with an issue and a held dispatch.
        bus.disp_rdy = 0;
        issue_tick(4'h7, 5'd3, 1, 32'h31, 5'd0, 1, 32'h32, 5'd0);
        issue_tick(4'h8, 5'd4, 0, 32'd0, 5'd15, 1, 32'h42, 5'd0);
        flush = 1;
        set_issue(4'h9, 5'd9, 1, 32'h91, 5'd0, 1, 32'h92, 5'd0, 5'd3);
        tick();
        flush = 0; bus.issue_vld = 0; bus.disp_rdy = 1;
        chk("flush_vld", bus.disp_vld, 0);
        chk("flush_full", bus.rs_full, 0);
        idle(3);

        // Reset in the middle of traffic.
        issue_tick(4'h0, 5'd11, 1, 32'h1, 5'd0, 1, 32'h2, 5'd0);
        issue_tick(4'h1, 5'd12, 1, 32'h3, 5'd0, 1, 32'h4, 5'd0);
        reset_and_check();
        idle(2);

        // Random traffic over a small tag space so wake-ups and collisions are frequent.
        for (int k = 0; k < 1500; k++) begin
            bus.issue_vld = ($urandom_range(0, 99) < 60);
            bus.issue_opcode = 4'($urandom_range(0, 11));
            bus.issue_tag = 5'($urandom_range(0, 31));
            bus.issue_shfamt = 5'($urandom_range(0, 31));
            bus.issue_src1_rdy = $urandom_range(0, 1) != 0;
            bus.issue_src1_val = $urandom;
            bus.issue_src1_tag = 5'($urandom_range(0, 7));
            bus.issue_src2_rdy = $urandom_range(0, 1) != 0;
            bus.issue_src2_val = $urandom;
            bus.issue_src2_tag = 5'($urandom_range(0, 7));
            bus.cdb_vld = ($urandom_range(0, 99) < 45);
            bus.cdb_tag = 5'($urandom_range(0, 7));
            bus.cdb_dat = $urandom;
            bus.disp_rdy = ($urandom_range(0, 99) < 70);
            flush = ($urandom_range(0, 99) < 2);
            tick();
        end
        flush = 0; bus.issue_vld = 0; bus.cdb_vld = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
